// File: rtl/channel_llr_buffer.sv
// Channel LLR frame register feeding stage 0 of the SC decoder; CHANNEL_PINGPONG_EN selects two banks.
// Latency: frame ready the cycle after the last beat; read data one cycle after the strobe.
// Backpressure: registered s_ready drops while no bank can take a new frame.
module channel_llr_buffer #(
  parameter int n = 3,
  parameter int p = 1,
  parameter int Q = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic [Q-1:0]                  s_llr,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic                          channel_register_ready,
  input  logic                          channel_register_rd_en,
  input  logic [(1<<(n-p-1))-1:0]       channel_register_addr,
  input  logic                          decoder_done,
  output logic [2*(1<<p)*Q-1:0]         channel_llr,
  output logic                          frame_err
);

  localparam int N = 1 << n;
  localparam int P = 1 << p;
  localparam int W = 1 << (n - p - 1);
`ifdef CHANNEL_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} bank_state_t;

  bank_state_t bank_state     [NB];
  bank_state_t bank_state_nxt [NB];
  logic [Q-1:0] mem [NB][N];

  logic [n-1:0] wcnt, wcnt_nxt;
  logic         wb, wb_nxt;
  logic         rb, rb_nxt;
  logic         err_nxt;
  logic         s_ready_nxt;
  logic         accept;

  assign accept                 = s_valid && s_ready;
  assign channel_register_ready = (bank_state[rb] == FULL);

  always_comb begin
    for (int b = 0; b < NB; b++) bank_state_nxt[b] = bank_state[b];
    wcnt_nxt = wcnt;
    wb_nxt   = wb;
    rb_nxt   = rb;
    err_nxt  = 1'b0;

    // Frames are consumed in the order they were loaded, so the read pointer
    // always advances to the other bank, even if that bank is still filling.
    if (decoder_done && channel_register_ready) begin
      bank_state_nxt[rb] = EMPTY;
`ifdef CHANNEL_PINGPONG_EN
      rb_nxt = ~rb;
`endif
    end

    if (accept) begin
      if (wcnt == n'(N-1)) begin
        bank_state_nxt[wb] = FULL;
        wcnt_nxt           = '0;
        err_nxt            = !s_last;
`ifdef CHANNEL_PINGPONG_EN
        wb_nxt = ~wb;
`endif
      end else if (s_last) begin
        bank_state_nxt[wb] = EMPTY;
        wcnt_nxt           = '0;
        err_nxt            = 1'b1;
      end else begin
        bank_state_nxt[wb] = LOADING;
        wcnt_nxt           = wcnt + n'(1);
      end
    end

    // The next load bank is only FULL when every bank holds an unread frame.
    s_ready_nxt = (bank_state_nxt[wb_nxt] != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) bank_state[b] <= EMPTY;
      wcnt      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      frame_err <= 1'b0;
      s_ready   <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) bank_state[b] <= bank_state_nxt[b];
      wcnt      <= wcnt_nxt;
      wb        <= wb_nxt;
      rb        <= rb_nxt;
      frame_err <= err_nxt;
      s_ready   <= s_ready_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wb][wcnt] <= s_llr;
  end

  logic                 sel_ok;
  int                   sel_j;
  logic [2*P*Q-1:0]     rd_word;

  always_comb begin
    sel_ok = (channel_register_addr != '0) &&
             ((channel_register_addr & (channel_register_addr - W'(1))) == '0);
    sel_j = 0;
    for (int k = 0; k < W; k++) begin
      if (channel_register_addr[k]) sel_j = k;
    end
  end

  // Even lanes carry the f-operand from the first half, odd lanes its g partner.
  always_comb begin
    rd_word = '0;
    for (int m = 0; m < P; m++) begin
      rd_word[2*m*Q +: Q]     = mem[rb][n'(sel_j*P + m)];
      rd_word[(2*m+1)*Q +: Q] = mem[rb][n'(sel_j*P + m + N/2)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      channel_llr <= '0;
    end else if (channel_register_rd_en && channel_register_ready) begin
      channel_llr <= sel_ok ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_channel_llr_buffer.sv
// Directed bench for channel_llr_buffer (n=3, p=1, Q=6); follows CHANNEL_PINGPONG_EN if defined.
module tb_channel_llr_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [5:0]  s_llr = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        channel_register_ready;
  logic        channel_register_rd_en = 1'b0;
  logic [1:0]  channel_register_addr = '0;
  logic        decoder_done = 1'b0;
  logic [23:0] channel_llr;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  channel_llr_buffer #(.n(3), .p(1), .Q(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_llr(s_llr),
    .s_last(s_last),
    .s_ready(s_ready),
    .channel_register_ready(channel_register_ready),
    .channel_register_rd_en(channel_register_rd_en),
    .channel_register_addr(channel_register_addr),
    .decoder_done(decoder_done),
    .channel_llr(channel_llr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {6'(l3), 6'(l2), 6'(l1), 6'(l0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat i carries base+i+1; last_idx < 0 means no s_last in the burst.
  task automatic send_frame(input int base, input int cnt, input int last_idx);
    for (int i = 0; i < cnt; i++) begin
      s_valid = 1'b1;
      s_llr   = 6'(base + i + 1);
      s_last  = (i == last_idx);
      for (int w = 0; w < 50 && !s_ready; w++) tick();
      if (!s_ready) begin
        checks++; failures++;
        $display("FAIL send_timeout beat=%0d s_ready=%b required=1", i, s_ready);
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] addr);
    channel_register_rd_en = 1'b1;
    channel_register_addr  = addr;
    tick();
    channel_register_rd_en = 1'b0;
    channel_register_addr  = '0;
  endtask

  task automatic pulse_done();
    decoder_done = 1'b1;
    tick();
    decoder_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (channel_register_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", channel_register_ready); end
    checks++; if (channel_llr !== 24'h0) begin failures++; $display("FAIL reset_llr got=%h exp=0", channel_llr); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_read();
    send_frame(0, 7, -1);
    checks++; if (channel_register_ready !== 1'b0) begin failures++; $display("FAIL ready_early got=%b exp=0", channel_register_ready); end
    do_read(2'b01);
    checks++; if (channel_llr !== 24'h0) begin failures++; $display("FAIL read_not_ready got=%h exp=0", channel_llr); end
    send_frame(7, 1, 0);
    checks++; if (channel_register_ready !== 1'b1) begin failures++; $display("FAIL ready_after_last got=%b exp=1", channel_register_ready); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL clean_err got=%b exp=0", frame_err); end
    do_read(2'b01);
    checks++; if (channel_llr !== pk(1, 5, 2, 6)) begin failures++; $display("FAIL read_w0 got=%h exp=%h", channel_llr, pk(1, 5, 2, 6)); end
    do_read(2'b10);
    checks++; if (channel_llr !== pk(3, 7, 4, 8)) begin failures++; $display("FAIL read_w1 got=%h exp=%h", channel_llr, pk(3, 7, 4, 8)); end
    do_read(2'b11);
    checks++; if (channel_llr !== 24'h0) begin failures++; $display("FAIL read_multi got=%h exp=0", channel_llr); end
    do_read(2'b01);
    checks++; if (channel_llr !== pk(1, 5, 2, 6)) begin failures++; $display("FAIL reread_w0 got=%h exp=%h", channel_llr, pk(1, 5, 2, 6)); end
    do_read(2'b00);
    checks++; if (channel_llr !== 24'h0) begin failures++; $display("FAIL read_zero got=%h exp=0", channel_llr); end
    do_read(2'b10);
    pulse_done();
    checks++; if (channel_register_ready !== 1'b0) begin failures++; $display("FAIL ready_after_done got=%b exp=0", channel_register_ready); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL s_ready_after_done got=%b exp=1", s_ready); end
    do_read(2'b01);
    checks++; if (channel_llr !== pk(3, 7, 4, 8)) begin failures++; $display("FAIL hold_when_empty got=%h exp=%h", channel_llr, pk(3, 7, 4, 8)); end
    pulse_done();
    checks++; if (channel_register_ready !== 1'b0) begin failures++; $display("FAIL done_ignored got=%b exp=0", channel_register_ready); end
  endtask

  task automatic test_frame_err();
    send_frame(0, 5, 4);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", frame_err); end
    tick();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL short_err_len got=%b exp=0", frame_err); end
    checks++; if (channel_register_ready !== 1'b0) begin failures++; $display("FAIL short_ready got=%b exp=0", channel_register_ready); end
    send_frame(10, 8, 7);
    checks++; if (channel_register_ready !== 1'b1) begin failures++; $display("FAIL recover_ready got=%b exp=1", channel_register_ready); end
    do_read(2'b01);
    checks++; if (channel_llr !== pk(11, 15, 12, 16)) begin failures++; $display("FAIL recover_w0 got=%h exp=%h", channel_llr, pk(11, 15, 12, 16)); end
    pulse_done();
    send_frame(20, 8, -1);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL nolast_err got=%b exp=1", frame_err); end
    checks++; if (channel_register_ready !== 1'b1) begin failures++; $display("FAIL nolast_ready got=%b exp=1", channel_register_ready); end
    do_read(2'b10);
    checks++; if (channel_llr !== pk(23, 27, 24, 28)) begin failures++; $display("FAIL nolast_w1 got=%h exp=%h", channel_llr, pk(23, 27, 24, 28)); end
    pulse_done();
  endtask

  task automatic test_back_to_back();
    send_frame(30, 8, 7);
`ifdef CHANNEL_PINGPONG_EN
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL pp_s_ready_a got=%b exp=1", s_ready); end
    send_frame(40, 8, 7);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL pp_both_full got=%b exp=0", s_ready); end
    checks++; if (channel_register_ready !== 1'b1) begin failures++; $display("FAIL pp_ready_b got=%b exp=1", channel_register_ready); end
    do_read(2'b01);
    checks++; if (channel_llr !== pk(31, 35, 32, 36)) begin failures++; $display("FAIL pp_read_a got=%h exp=%h", channel_llr, pk(31, 35, 32, 36)); end
    pulse_done();
    checks++; if (channel_register_ready !== 1'b1) begin failures++; $display("FAIL pp_swap_ready got=%b exp=1", channel_register_ready); end
    do_read(2'b01);
    checks++; if (channel_llr !== pk(41, 45, 42, 46)) begin failures++; $display("FAIL pp_read_b got=%h exp=%h", channel_llr, pk(41, 45, 42, 46)); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL pp_s_ready_free got=%b exp=1", s_ready); end
    send_frame(50, 7, -1);
    s_valid = 1'b1; s_llr = 6'd58; s_last = 1'b1; decoder_done = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0; decoder_done = 1'b0;
    checks++; if (channel_register_ready !== 1'b1) begin failures++; $display("FAIL pp_same_cycle_ready got=%b exp=1", channel_register_ready); end
    do_read(2'b10);
    checks++; if (channel_llr !== pk(53, 57, 54, 58)) begin failures++; $display("FAIL pp_read_c got=%h exp=%h", channel_llr, pk(53, 57, 54, 58)); end
    pulse_done();
    checks++; if (channel_register_ready !== 1'b0) begin failures++; $display("FAIL pp_drain got=%b exp=0", channel_register_ready); end
`else
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL sb_s_ready_full got=%b exp=0", s_ready); end
    s_valid = 1'b1; s_llr = 6'd41; s_last = 1'b0;
    tick(); tick(); tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL sb_s_ready_hold got=%b exp=0", s_ready); end
    s_valid = 1'b0;
    do_read(2'b01);
    checks++; if (channel_llr !== pk(31, 35, 32, 36)) begin failures++; $display("FAIL sb_read_a got=%h exp=%h", channel_llr, pk(31, 35, 32, 36)); end
    pulse_done();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL sb_s_ready_done got=%b exp=1", s_ready); end
    checks++; if (channel_register_ready !== 1'b0) begin failures++; $display("FAIL sb_ready_done got=%b exp=0", channel_register_ready); end
    send_frame(40, 8, 7);
    do_read(2'b01);
    checks++; if (channel_llr !== pk(41, 45, 42, 46)) begin failures++; $display("FAIL sb_read_b got=%h exp=%h", channel_llr, pk(41, 45, 42, 46)); end
    pulse_done();
`endif
  endtask

  task automatic test_reset_mid_load();
    send_frame(0, 4, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (channel_llr !== 24'h0) begin failures++; $display("FAIL mid_reset_llr got=%h exp=0", channel_llr); end
    checks++; if (s_ready !== 1'b1 || channel_register_ready !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL mid_reset_flags got=%b%b%b exp=100", s_ready, channel_register_ready, frame_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(20, 8, 7);
    checks++; if (channel_register_ready !== 1'b1 || frame_err !== 1'b0) begin
      failures++; $display("FAIL post_reset_frame got=%b%b exp=10", channel_register_ready, frame_err);
    end
    do_read(2'b10);
    checks++; if (channel_llr !== pk(23, 27, 24, 28)) begin failures++; $display("FAIL post_reset_w1 got=%h exp=%h", channel_llr, pk(23, 27, 24, 28)); end
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
